ysyx_22040895_mdu_seq: RTL and testbench
========================================

Name: ysyx_22040895_mdu_seq

Overview:
- Multi-cycle sequencer and iterative datapath for the RV64M subset that the decoder flags on its 4-bit mduop: mul, mulw, divw, remw.
- Sits beside the ALU in the execute stage. Accepts one operation at a time through a valid/ready handshake.
- Holds busy_o high so the pipeline stalls while it works, then pulses done_o with the 64-bit result for writeback.
- Performs multiplication with shift-add steps and division with restoring steps on magnitudes, followed by a sign fix-up.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- MUL_STEPS, 64, iteration cycles for mul.
- W_STEPS, 32, iteration cycles for mulw, divw and remw.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  operation request.
- mduop_i  in  4  decoder encoding: bit0 = md op present; bits[3:2] select the op: 00 mul, 01 mulw, 10 divw, 11 remw.
- src1_i  in  64  rs1 value.
- src2_i  in  64  rs2 value.
- flush_i  in  1  abort the current operation (redirect or trap).
- ready_o  out  1  high only in IDLE.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  64  registered result.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, all counters and operand registers = 0, done_o = 0, result_o = 0, busy_o = 0, ready_o = 1. Reset asserted mid-operation discards the operation; no done_o follows.
- Accept: on a clk edge with valid_i & ready_o & mduop_i[0] & ~flush_i, latch the op and operands. valid_i with mduop_i[0] = 0 is ignored. No request is accepted in any state other than IDLE.
- States:
  - IDLE.
  - MUL: MUL_STEPS or W_STEPS cycles.
  - DIV: W_STEPS cycles.
  - FIX: 1 cycle, applies quotient/remainder sign.
  - DONE: 1 cycle, done_o = 1.
  - DONE always returns to IDLE.
- Latency: done_o is high in cycle N after the accept cycle (the accept cycle is cycle 0):
  - mul: N = 65.
  - mulw: N = 33.
  - divw / remw: N = 34.
  - divide special cases: N = 1 (IDLE -> DONE directly).
- mul: 64x64 product, low 64 bits returned. Two's-complement wrap, so operand signs need no handling.
- mulw: src1[31:0] * src2[31:0], low 32 bits sign-extended to 64.
- divw / remw:
  - Operands are src[31:0], signed.
  - Iterate on magnitudes over 32 steps with a 33-bit partial remainder.
  - FIX negates the quotient when the operand signs differ, and negates the remainder when the dividend is negative.
  - The 32-bit result is sign-extended to 64.
- Divide special cases, detected at accept:
  - Divisor[31:0] = 0: quotient = 0xFFFFFFFFFFFFFFFF; remainder = sext(dividend[31:0]).
  - Dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0xFFFFFFFF80000000; remainder = 0.
- result_o updates only on entry to DONE and holds its value until the next DONE or reset.
- done_o is high exactly one cycle per completed operation.
- flush_i = 1 in any state: next edge goes to IDLE, done_o is not asserted, result_o is unchanged. flush_i in IDLE blocks acceptance in that cycle. flush_i has priority over completion in DONE: done_o is still high that cycle, since it is registered, but the bench treats that result as squashed.
- Back-to-back: the earliest next accept is the cycle after DONE, i.e. when ready_o has returned high.
- Operands are latched at accept, so changes on src*_i during busy have no effect.

Test Plan:
- mul 3 * 0xFFFFFFFFFFFFFFFB (-5) -> done_o in cycle 65, result 0xFFFFFFFFFFFFFFF1; busy_o high in cycles 1-65, ready_o low over the same cycles.
- mulw 0x40000000 * 2 -> cycle 33, 0xFFFFFFFF80000000. mulw 0x1_00000003 * 0x5 -> 0x000000000000000F (upper bits ignored).
- divw 0xFFFFFFF9 (-7) / 2 -> cycle 34, 0xFFFFFFFFFFFFFFFD. remw with the same operands -> 0xFFFFFFFFFFFFFFFF.
- divw 100 / 0 -> cycle 1, 0xFFFFFFFFFFFFFFFF. remw 100 / 0 -> 0x64. divw 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000. remw with the same operands -> 0.
- Start mul, assert flush_i in cycle 20 -> IDLE in cycle 21, no done_o, result_o unchanged. A new divw accepted in cycle 21 completes correctly.
- Start divw, drive rst low in cycle 10 -> all outputs go to their reset values immediately. Release rst -> ready_o = 1 and no spurious done_o.

Source files
------------

// File: rtl/ysyx_22040895_mdu_seq_if.sv
// rtl/ysyx_22040895_mdu_seq_if.sv - request/result bundle between the execute stage and the MDU
// Purpose: groups the MDU handshake, operands, flush and result into one port.
// Signals:
//   valid_i, mduop_i[3:0], src1_i, src2_i, flush_i : requester -> MDU
//   ready_o, busy_o, done_o, result_o              : MDU -> requester
interface ysyx_22040895_mdu_seq_if #(
  parameter int XLEN = 64
);
  logic            valid_i;
  logic [3:0]      mduop_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, mduop_i, src1_i, src2_i, flush_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, mduop_i, src1_i, src2_i, flush_i,
    output ready_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ysyx_22040895_mdu_seq.sv
// rtl/ysyx_22040895_mdu_seq.sv - multi-cycle sequencer and iterative datapath for mul/mulw/divw/remw
// Purpose: accepts one RV64M operation at a time, iterates shift-add (mul) or
//   restoring division on magnitudes (div), fixes signs, then pulses done_o.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of ysyx_22040895_mdu_seq_if
//          (valid_i, mduop_i, src1_i, src2_i, flush_i in;
//           ready_o, busy_o, done_o, result_o out)
module ysyx_22040895_mdu_seq #(
  parameter int XLEN      = 64,
  parameter int MUL_STEPS = 64,
  parameter int W_STEPS   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22040895_mdu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULW = 2'b01;
  localparam logic [1:0] OP_REMW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [31:0]      r_quo;
  logic [31:0]      r_rem;
  logic [31:0]      r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [XLEN-1:0]  r_result;

  // ---------------------------------------------------------------- request decode
  logic            w_accept;
  logic [1:0]      w_op;
  logic            w_is_div;
  logic [31:0]     w_a32;
  logic [31:0]     w_b32;
  logic [31:0]     w_a_mag;
  logic [31:0]     w_b_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_unused_op1;

  assign w_op         = bus.mduop_i[3:2];
  assign w_is_div     = w_op[1];
  assign w_unused_op1 = bus.mduop_i[1];
  assign w_accept     = bus.valid_i & (r_state == S_IDLE) & bus.mduop_i[0] & ~bus.flush_i;
  assign w_a32        = bus.src1_i[31:0];
  assign w_b32        = bus.src2_i[31:0];
  assign w_a_mag      = w_a32[31] ? (~w_a32 + 32'd1) : w_a32;
  assign w_b_mag      = w_b32[31] ? (~w_b32 + 32'd1) : w_b32;
  assign w_div_zero   = (w_b32 == 32'd0);
  assign w_div_ovf    = (w_a32 == 32'h8000_0000) && (w_b32 == 32'hFFFF_FFFF);
  assign w_special    = w_is_div & (w_div_zero | w_div_ovf);

  // Results for the cases that bypass the iteration entirely.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = (w_op == OP_REMW) ? {{(XLEN-32){w_a32[31]}}, w_a32} : '1;
    end else if (w_op != OP_REMW) begin
      w_special_res = {{(XLEN-32){1'b1}}, 32'h8000_0000};
    end
  end

  // ---------------------------------------------------------------- shift-add step
  logic [XLEN-1:0] w_acc_next;
  logic [XLEN-1:0] w_mul_res;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res  = (r_op == OP_MULW) ? {{(XLEN-32){w_acc_next[31]}}, w_acc_next[31:0]}
                                        : w_acc_next;

  // ---------------------------------------------------------------- restoring divide step
  // The 33-bit shifted partial remainder never exceeds 2^32-1; bit 32 of the
  // difference is the borrow that decides the quotient bit.
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;

  assign w_rem_sh   = {r_rem, r_quo[31]};
  assign w_diff     = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[32];
  assign w_rem_next = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];

  // ---------------------------------------------------------------- sign fix-up
  logic [31:0]     w_q_fix;
  logic [31:0]     w_r_fix;
  logic [31:0]     w_fix32;
  logic [XLEN-1:0] w_fix_res;

  assign w_q_fix   = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix   = r_neg_r ? (~r_rem + 32'd1) : r_rem;
  assign w_fix32   = (r_op == OP_REMW) ? w_r_fix : w_q_fix;
  assign w_fix_res = {{(XLEN-32){w_fix32[31]}}, w_fix32};

  // ---------------------------------------------------------------- FSM
  logic            w_res_load;
  logic [XLEN-1:0] w_res_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_res_load = 1'b0;
    w_res_val  = w_mul_res;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_next     = S_DONE;
            w_res_load = 1'b1;
            w_res_val  = w_special_res;
          end else begin
            w_next = w_is_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_next     = S_DONE;
          w_res_load = 1'b1;
          w_res_val  = w_mul_res;
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next     = S_DONE;
        w_res_load = 1'b1;
        w_res_val  = w_fix_res;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Flush wins over everything, including the result write on entry to DONE.
    if (bus.flush_i) begin
      w_next     = S_IDLE;
      w_res_load = 1'b0;
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= w_op;
        r_cnt <= (w_op == OP_MUL) ? CNT_W'(MUL_STEPS - 1) : CNT_W'(W_STEPS - 1);
        r_acc <= '0;
        if (w_op == OP_MUL) begin
          r_mcand  <= bus.src1_i;
          r_mplier <= bus.src2_i;
        end else begin
          // Low 32 bits of the product do not depend on operand sign.
          r_mcand  <= {{(XLEN-32){1'b0}}, w_a32};
          r_mplier <= {{(XLEN-32){1'b0}}, w_b32};
        end
        r_quo   <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_rem   <= '0;
        r_neg_q <= w_a32[31] ^ w_b32[31];
        r_neg_r <= w_a32[31];
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
      end else if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_quo <= {r_quo[30:0], w_qbit};
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_res_load) begin
        r_result <= w_res_val;
      end
    end
  end

  assign bus.ready_o  = (r_state == S_IDLE);
  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.done_o   = (r_state == S_DONE);
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_ysyx_22040895_mdu_seq.sv
// tb/tb_ysyx_22040895_mdu_seq.sv - directed vector bench for ysyx_22040895_mdu_seq
module tb_ysyx_22040895_mdu_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  ysyx_22040895_mdu_seq_if ifc ();

  ysyx_22040895_mdu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; accepts on the next posedge, then watches for done_o.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] res, output bit hs_ok);
    hs_ok = (ifc.ready_o === 1'b1) && (ifc.busy_o === 1'b0);
    ifc.valid_i = 1'b1;
    ifc.mduop_i = {op, 2'b01};
    ifc.src1_i  = a;
    ifc.src2_i  = b;
    @(posedge clk);
    @(negedge clk);
    ifc.valid_i = 1'b0;
    ifc.src1_i  = 64'hA5A5_5A5A_0000_0000;
    ifc.src2_i  = 64'h0F0F_F0F0_0000_0000;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 200; c++) begin
      if (!(ifc.busy_o === 1'b1 && ifc.ready_o === 1'b0)) hs_ok = 1'b0;
      if (ifc.done_o === 1'b1) begin
        lat = c;
        res = ifc.result_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    bit          hs_ok;
    bit          saw_done;
    bit          ready_ok;

    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = '{2'b00, 64'd3,                    64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
    vecs[1]  = '{2'b01, 64'h4000_0000,            64'd2,                   64'hFFFF_FFFF_8000_0000, 33};
    vecs[2]  = '{2'b01, 64'h1_0000_0003,          64'd5,                   64'h0000_0000_0000_000F, 33};
    vecs[3]  = '{2'b10, 64'hFFFF_FFF9,            64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[4]  = '{2'b11, 64'hFFFF_FFF9,            64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[5]  = '{2'b10, 64'd100,                  64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{2'b11, 64'd100,                  64'd0,                   64'h0000_0000_0000_0064, 1};
    vecs[7]  = '{2'b10, 64'h8000_0000,            64'hFFFF_FFFF,           64'hFFFF_FFFF_8000_0000, 1};
    vecs[8]  = '{2'b11, 64'h8000_0000,            64'hFFFF_FFFF,           64'h0000_0000_0000_0000, 1};
    vecs[9]  = '{2'b00, 64'h1_2345_6789,          64'h1000,                64'h0000_1234_5678_9000, 65};
    vecs[10] = '{2'b10, 64'd7,                    64'hFFFF_FFFE,           64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[11] = '{2'b11, 64'd7,                    64'hFFFF_FFFE,           64'h0000_0000_0000_0001, 34};
    vecs[12] = '{2'b11, 64'hFFFF_FF9C,            64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 34};
    vecs[13] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 65};
    vecs[14] = '{2'b01, 64'hFFFF_FFFF,            64'hFFFF_FFFF,           64'h0000_0000_0000_0001, 33};
    vecs[15] = '{2'b10, 64'hDEAD_0000_0000_0014,  64'hFFFF_0000_0000_0003, 64'h0000_0000_0000_0006, 34};

    ifc.valid_i = 1'b0;
    ifc.mduop_i = 4'h0;
    ifc.src1_i  = '0;
    ifc.src2_i  = '0;
    ifc.flush_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", 64'(ifc.ready_o), 64'd1);
    check("reset busy", 64'(ifc.busy_o), 64'd0);
    check("reset done", 64'(ifc.done_o), 64'd0);
    check("reset result", ifc.result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // valid without the md-op bit is ignored
    ifc.valid_i = 1'b1;
    ifc.mduop_i = 4'b0000;
    ifc.src1_i  = 64'd3;
    ifc.src2_i  = 64'd4;
    @(posedge clk);
    @(negedge clk);
    ifc.valid_i = 1'b0;
    check("no-op ignored busy", 64'(ifc.busy_o), 64'd0);

    // flush in IDLE blocks the accept
    ifc.valid_i = 1'b1;
    ifc.mduop_i = 4'b0001;
    ifc.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.valid_i = 1'b0;
    ifc.flush_i = 1'b0;
    check("idle flush blocks", 64'(ifc.busy_o), 64'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, hs_ok);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d result", i), res, vecs[i].exp);
      check($sformatf("v%0d busy/ready", i), 64'(hs_ok), 64'd1);
      @(negedge clk);
      check($sformatf("v%0d done one cycle", i), {62'd0, ifc.done_o, ifc.ready_o}, 64'd1);
      check($sformatf("v%0d result hold", i), ifc.result_o, vecs[i].exp);
    end

    // flush a mul in cycle 20, then a divw accepted in cycle 21
    ifc.valid_i = 1'b1;
    ifc.mduop_i = 4'b0001;
    ifc.src1_i  = 64'd11;
    ifc.src2_i  = 64'd13;
    @(posedge clk);
    @(negedge clk);
    ifc.valid_i = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (ifc.done_o === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    ifc.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.flush_i = 1'b0;
    if (ifc.done_o === 1'b1) saw_done = 1'b1;
    check("flush no done", 64'(saw_done), 64'd0);
    check("flush idle", 64'(ifc.ready_o), 64'd1);
    check("flush result kept", ifc.result_o, vecs[15].exp);
    run_op(2'b10, 64'd1000, 64'hFFFF_FFF6, lat, res, hs_ok);
    check("post-flush latency", 64'(lat), 64'd34);
    check("post-flush result", res, 64'hFFFF_FFFF_FFFF_FF9C);
    @(negedge clk);

    // reset in cycle 10 of a divw
    ifc.valid_i = 1'b1;
    ifc.mduop_i = 4'b1001;
    ifc.src1_i  = 64'd50;
    ifc.src2_i  = 64'd7;
    @(posedge clk);
    @(negedge clk);
    ifc.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop reset ready", 64'(ifc.ready_o), 64'd1);
    check("midop reset busy", 64'(ifc.busy_o), 64'd0);
    check("midop reset done", 64'(ifc.done_o), 64'd0);
    check("midop reset result", ifc.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    ready_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ifc.done_o !== 1'b0) saw_done = 1'b1;
      if (ifc.ready_o !== 1'b1) ready_ok = 1'b0;
    end
    check("post-reset no done", 64'(saw_done), 64'd0);
    check("post-reset ready", 64'(ready_ok), 64'd1);

    run_op(2'b01, 64'd7, 64'd6, lat, res, hs_ok);
    check("post-reset mulw latency", 64'(lat), 64'd33);
    check("post-reset mulw result", res, 64'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
